// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc: button-driven RPN calculator with a DEPTH-entry operand stack.
// Raw buttons are synchronised and edge-detected; a single FSM handles push,
// exec and clear, and flags overflow/underflow in a sticky error bit.
// Optional feature macro: RPN_MUL_EN (op 11 becomes a*b instead of a^b).
module rpn_stack_calc #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [W-1:0]                 sw,
    input  logic [1:0]                   op,
    input  logic [2:0]                   btn,
    output logic [W-1:0]                 ld,
    output logic [W-1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);
    localparam logic [DW-1:0] ONE  = DW'(1);
    localparam logic [DW-1:0] TWO  = DW'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PART  = 2'd1,
        S_READY = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t          state_q;
    logic [W-1:0]    stack_q [DEPTH];
    logic [W-1:0]    ld_q;
    logic [DW-1:0]   depth_q;
    logic            err_q;

    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      dly_q;
    logic [2:0]      pulse;
    logic [W-1:0]    alu_r;

    // Result of the selected operation; all arithmetic wraps modulo 2^W.
    function automatic logic [W-1:0] alu(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [1:0]   sel);
        logic [W-1:0] r;
        case (sel)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
`ifdef RPN_MUL_EN
            default: r = a * b;
`else
            default: r = a ^ b;
`endif
        endcase
        return r;
    endfunction

    // Two-flop synchroniser plus a delay flop per button for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~dly_q;
    assign alu_r = alu(stack_q[1], stack_q[0], op);

    // Calculator FSM: clear beats exec beats push when pulses coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            ld_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else if (pulse[2]) begin
            state_q <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            ld_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else if (pulse[1]) begin
            case (state_q)
                S_READY: begin
                    stack_q[0] <= alu_r;
                    for (int i = 1; i < DEPTH - 1; i++) stack_q[i] <= stack_q[i+1];
                    stack_q[DEPTH-1] <= '0;
                    ld_q    <= alu_r;
                    depth_q <= depth_q - ONE;
                    state_q <= (depth_q == TWO) ? S_PART : S_READY;
                end
                S_IDLE, S_PART: begin
                    err_q   <= 1'b1;
                    state_q <= S_ERR;
                end
                default: ;
            endcase
        end else if (pulse[0]) begin
            if (state_q != S_ERR) begin
                if (depth_q == FULL) begin
                    err_q   <= 1'b1;
                    state_q <= S_ERR;
                end else begin
                    for (int i = DEPTH - 1; i > 0; i--) stack_q[i] <= stack_q[i-1];
                    stack_q[0] <= sw;
                    depth_q    <= depth_q + ONE;
                    state_q    <= ((depth_q + ONE) >= TWO) ? S_READY : S_PART;
                end
            end
        end
    end

    assign ld    = ld_q;
    assign top   = stack_q[0];
    assign depth = depth_q;
    assign err   = err_q;

endmodule
